// File: rtl/load_store_unit.sv
// Load/store bridge between execute stage and word-addressed data cache.
// Optional alignment faulting is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WORD_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_BITS-1:0] resp_rdata,
    output logic                 resp_misaligned,
    output logic [ADDR_BITS-1:0] cache_address,
    input  logic [WORD_BITS-1:0] cache_rd_data,
    output logic [WORD_BITS-1:0] cache_wr_data,
    output logic                 cache_wr_en
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 write_q;
    logic [1:0]           size_q;
    logic                 signed_q;
    logic [1:0]           addr_lo_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic [WORD_BITS-1:0] data_q;
    logic                 misaligned_q;
    logic                 resp_valid_q;
    logic [WORD_BITS-1:0] resp_rdata_q;
    logic                 resp_misaligned_q;
    logic [ADDR_BITS-1:0] cache_address_q;
    logic [WORD_BITS-1:0] cache_wr_data_q;
    logic                 cache_wr_en_q;

    logic                 mis_now;
    logic [WORD_BITS-1:0] merged;
    logic [WORD_BITS-1:0] load_result;
    logic [7:0]           lane_b;
    logic [15:0]          lane_h;

    assign req_ready       = (state_q == StIdle);
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_misaligned_q;
    assign cache_address   = cache_address_q;
    assign cache_wr_data   = cache_wr_data_q;
    assign cache_wr_en     = cache_wr_en_q;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_now = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    // Little-endian lane merge of store data into the captured word.
    always_comb begin
        merged = data_q;
        if (size_q[1]) begin
            merged = wdata_q;
        end else if (size_q[0]) begin
            if (addr_lo_q[1]) merged[31:16] = wdata_q[15:0];
            else              merged[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        lane_b = data_q[{addr_lo_q, 3'b000} +: 8];
        lane_h = data_q[{addr_lo_q[1], 4'b0000} +: 16];
        if (size_q[1]) begin
            load_result = data_q;
        end else if (size_q[0]) begin
            load_result = {{16{signed_q & lane_h[15]}}, lane_h};
        end else begin
            load_result = {{24{signed_q & lane_b[7]}}, lane_b};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (mis_now)                      state_d = StResp;
                    else if (req_write && req_size[1]) state_d = StWrite;
                    else                              state_d = StRead;
                end
            end
            StRead:  state_d = write_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  if (resp_valid_q && resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Cache and response outputs are registered on leaving each state, so the
    // write strobe lags WRITE by one cycle and resp_valid rises one cycle into RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            write_q           <= 1'b0;
            size_q            <= 2'b00;
            signed_q          <= 1'b0;
            addr_lo_q         <= 2'b00;
            wdata_q           <= '0;
            data_q            <= '0;
            misaligned_q      <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= '0;
            resp_misaligned_q <= 1'b0;
            cache_address_q   <= '0;
            cache_wr_data_q   <= '0;
            cache_wr_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cache_wr_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        size_q       <= req_size;
                        signed_q     <= req_signed;
                        addr_lo_q    <= req_addr[1:0];
                        wdata_q      <= req_wdata;
                        misaligned_q <= mis_now;
                        if (!mis_now) cache_address_q <= {req_addr[ADDR_BITS-1:2], 2'b00};
                    end
                end
                StRead: data_q <= cache_rd_data;
                StWrite: begin
                    cache_wr_en_q   <= 1'b1;
                    cache_wr_data_q <= merged;
                end
                StResp: begin
                    if (!resp_valid_q) begin
                        resp_valid_q      <= 1'b1;
                        resp_misaligned_q <= misaligned_q;
                        resp_rdata_q      <= (!write_q && !misaligned_q) ? load_result : '0;
                    end else if (resp_ready) begin
                        resp_valid_q      <= 1'b0;
                        resp_misaligned_q <= 1'b0;
                        resp_rdata_q      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 128-word cache.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_misaligned;
    logic [31:0] resp_rdata;
    logic [8:0]  cache_address;
    logic [31:0] cache_rd_data, cache_wr_data;
    logic        cache_wr_en;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          wrs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[128] = '{default: 32'h0};
    logic [31:0] ref_mem[128] = '{default: 32'h0};
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    load_store_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_misaligned(resp_misaligned),
        .cache_address  (cache_address),
        .cache_rd_data  (cache_rd_data),
        .cache_wr_data  (cache_wr_data),
        .cache_wr_en    (cache_wr_en)
    );

    always #5 clk = ~clk;

    assign cache_rd_data = mem[cache_address[8:2]];

    always @(posedge clk) begin
        if (cache_wr_en) begin
            mem[cache_address[8:2]] <= cache_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [8:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] lo);
        logic [31:0] v;
        int          sh;
        if (sz[1]) return w;
        if (sz == 2'b00) begin
            sh = 8 * int'(lo);
            v  = (w >> sh) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            sh = lo[1] ? 16 : 0;
            v  = (w >> sh) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        if (sz[1]) return d;
        mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2'b00) ? 8 * int'(lo) : (lo[1] ? 16 : 0);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic exp_t model_req(input logic w, input logic [1:0] sz, input logic sg,
                                       input logic [8:0] a, input logic [31:0] wd);
        exp_t e;
        int   idx;
        idx     = int'(a[8:2]);
        e.mis   = model_mis(sz, a);
        e.rdata = 32'h0;
        e.wrs   = 0;
        if (e.mis) begin
            e.lat = 1;
        end else if (w) begin
            ref_mem[idx] = model_store(ref_mem[idx], sz, a[1:0], wd);
            e.lat = sz[1] ? 2 : 3;
            e.wrs = 1;
        end else begin
            e.rdata = model_load(ref_mem[idx], sz, sg, a[1:0]);
            e.lat   = 2;
        end
        return e;
    endfunction

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd, output logic [31:0] rd);
        exp_t e;
        int   n;
        int   wr_base;
        int   idx;
        idx = int'(a[8:2]);
        @(negedge clk);
        check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
        drive(w, sz, sg, a, wd);
        sb.push_back(model_req(w, sz, sg, a, wd));
        wr_base = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 20);
        e = sb.pop_front();
        if (resp_valid) begin
            check_eq("latency", n, e.lat);
            check_eq("rdata", resp_rdata, e.rdata);
            check_eq("misaligned", {31'b0, resp_misaligned}, {31'b0, e.mis});
            check_eq("wr_count", wr_cnt - wr_base, e.wrs);
            rd = resp_rdata;
        end else begin
            check_eq("resp_timeout", {31'b0, resp_valid}, 32'd1);
            rd = 32'h0;
        end
        check_eq("cache_word", mem[idx], ref_mem[idx]);
        @(posedge clk);
        #1 check_eq("resp_drop", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        exp_t        e;
        int          n;
        int          wr_base;
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 9'h0, 32'h0);
        req_valid  = 1'b0;
        #3;
        check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
        check_eq("rst_cache_addr", {23'b0, cache_address}, 32'd0);
        check_eq("rst_wr_data", cache_wr_data, 32'd0);
        check_eq("rst_wr_en", {31'b0, cache_wr_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 9'h10, 32'h1122_3344, rd);
        check_eq("tp_word_mem", mem[4], 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 9'h10, 32'h0, rd);
        check_eq("tp_word_load", rd, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 9'h12, 32'h0000_00AA, rd);
        check_eq("tp_byte_merge", mem[4], 32'h11AA_3344);
        issue(1'b0, 2'b00, 1'b1, 9'h12, 32'h0, rd);
        check_eq("tp_lb_signed", rd, 32'hFFFF_FFAA);
        issue(1'b0, 2'b00, 1'b0, 9'h12, 32'h0, rd);
        check_eq("tp_lb_unsigned", rd, 32'h0000_00AA);
        issue(1'b0, 2'b01, 1'b1, 9'h12, 32'h0, rd);
        check_eq("tp_lh_hi", rd, 32'h0000_11AA);
        issue(1'b0, 2'b01, 1'b1, 9'h10, 32'h0, rd);
        check_eq("tp_lh_lo", rd, 32'h0000_3344);

        // Halfword to an odd address: faults when checking is on, else lands in lane 0.
        issue(1'b1, 2'b01, 1'b0, 9'h11, 32'h0000_BEEF, rd);
`ifdef LSU_MISALIGN_CHECK_EN
        check_eq("tp_mis_mem", mem[4], 32'h11AA_3344);
`else
        check_eq("tp_mis_mem", mem[4], 32'h11AA_BEEF);
`endif

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 63)), $urandom, rd);
        end

        // Backpressure: a second request is held on req_valid while the response stalls.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 9'h10, 32'h0);
        sb.push_back(model_req(1'b0, 2'b10, 1'b0, 9'h10, 32'h0));
        wr_base = wr_cnt;
        @(posedge clk);
        #1 drive(1'b1, 2'b10, 1'b0, 9'h20, 32'hDEAD_BEEF);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 20);
        e = sb.pop_front();
        check_eq("bp_latency", n, e.lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", {31'b0, resp_valid}, 32'd1);
            check_eq("bp_rdata", resp_rdata, e.rdata);
            check_eq("bp_mis", {31'b0, resp_misaligned}, 32'd0);
            check_eq("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 check_eq("bp_release", {31'b0, resp_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_no_extra_resp", {31'b0, resp_valid}, 32'd0);
        check_eq("bp_no_write", wr_cnt - wr_base, 0);
        check_eq("bp_mem_unchanged", mem[8], ref_mem[8]);

        // Reset during READ of a byte store: the write must never happen.
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 9'h21, 32'h0000_0055);
        wr_base = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_wr_en", {31'b0, cache_wr_en}, 32'd0);
        check_eq("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_mid_addr", {23'b0, cache_address}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rel_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rel_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_no_write", wr_cnt - wr_base, 0);
        check_eq("rst_mem_unchanged", mem[8], ref_mem[8]);
        check_eq("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential bridge between the processor execute stage and the word-addressed data cache. Accepts byte, halfword and word loads and stores over a valid/ready request port. Performs sub-word stores as read-modify-write and sign- or zero-extends sub-word loads. Returns one response per request over a valid/ready response port. It is the only master of the data cache's address, write-data and write-enable inputs.

## Interface
Parameters:
- WORD_BITS, 32, data width; fixed at 32 for byte-lane logic.
- ADDR_BITS, 9, byte address width; matches a 128-word cache.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state on the rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
- Request port:
  - req_valid  in  1  request present.
  - req_ready  out  1  unit can accept a request.
  - req_write  in  1  1 = store, 0 = load.
  - req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
  - req_signed  in  1  sign-extend sub-word loads.
  - req_addr  in  ADDR_BITS  byte address.
  - req_wdata  in  WORD_BITS  store data, right-aligned.
- Response port:
  - resp_valid  out  1  response present.
  - resp_ready  in  1  consumer takes the response.
  - resp_rdata  out  WORD_BITS  load result; 0 for stores and faults.
  - resp_misaligned  out  1  request faulted on alignment.
- Cache port:
  - cache_address  out  ADDR_BITS  byte address, low 2 bits always 0.
  - cache_rd_data  in  WORD_BITS  combinational read of the word at cache_address.
  - cache_wr_data  out  WORD_BITS  word to write.
  - cache_wr_en  out  1  write strobe; the cache writes on the next rising edge.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields and compute the aligned address {req_addr[ADDR_BITS-1:2],2'b00}.
- Transitions from IDLE on accept:
  - Misaligned request (halfword with addr[0]=1, or word with addr[1:0]≠0) → RESP with resp_misaligned=1; no cache access.
  - Load, or sub-word store → READ.
  - Word store → WRITE, with cache_wr_data=req_wdata.
- READ:
  - cache_address = aligned address; capture cache_rd_data into the data register.
  - Load → RESP.
  - Sub-word store → WRITE.
- Sub-word store merge (little-endian):
  - Byte replaces bits [8*a+7:8*a], where a=addr[1:0].
  - Halfword replaces bits [16*addr[1]+15:16*addr[1]].
  - All other bits keep the captured word.
- WRITE: cache_wr_en=1 for exactly one cycle, then → RESP.
- Load extraction uses the same lanes. Sub-word results are zero-extended, or sign-extended from the lane MSB when req_signed=1. Word loads are returned unchanged.
- RESP:
  - resp_valid=1; outputs are held stable until resp_ready=1, then → IDLE.
  - req_ready=0 in every state except IDLE; no request overlap.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, cache_address=0, cache_wr_data=0, cache_wr_en=0.
- cache_address holds its last value outside READ and WRITE.

## Timing
- Accept edge = edge 0. resp_valid rises after:
  - Misaligned: edge 1.
  - Load: edge 2.
  - Word store: edge 2; the cache commits at edge 2.
  - Sub-word store: edge 3; the cache commits at edge 3.
- Response lasts one cycle minimum. The earliest next accept is the cycle after the resp_valid&&resp_ready edge.
- cache_wr_en and cache_wr_data are registered outputs; there is no combinational path from req_* to the cache port.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately and asynchronously.
  - A WRITE in progress is dropped if reset_n falls before its commit edge.
  - An outstanding response is discarded.
- Reset deasserted: IDLE, with req_ready=1 in the first cycle.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: alignment faults behave as described above.
- LSU_MISALIGN_CHECK_EN undefined:
  - resp_misaligned is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - Every request performs its normal cache access.

## Test plan
- Word store then load:
  - Store 0x11223344 to 0x10 → cache_wr_en high one cycle with data 0x11223344.
  - Load word 0x10 → resp_rdata=0x11223344 at edge 2.
- Byte store merge: store byte 0xAA to 0x12 → READ then WRITE; cache word at 0x10 becomes 0x11AA3344; resp_valid at edge 3.
- Extension, on word 0x11AA3344 at 0x10:
  - Signed byte load 0x12 → 0xFFFFFFAA; unsigned → 0x000000AA.
  - Signed halfword load 0x12 → 0x000011AA.
  - Signed halfword load 0x10 → 0x00003344.
- Misalignment:
  - Halfword store to 0x11 → resp_misaligned=1 at edge 1; cache_wr_en never asserted; cache unchanged.
  - Repeat without LSU_MISALIGN_CHECK_EN → the halfword is written to 0x10.
- Backpressure: hold resp_ready=0 for 5 cycles after a load → resp_valid, resp_rdata and resp_misaligned stable; req_ready=0 throughout; a new req_valid is not accepted.
- Reset mid-store:
  - Drop reset_n during READ of a byte store → cache_wr_en stays 0 and the target word is unchanged.
  - After release: req_ready=1 and resp_valid=0.
